// File: rtl/mandel_iter_ctrl.sv
// Mandelbrot iteration sequencer: time-shares one Q10.21 multiplier across x*x, y*y, x*y per z-update.
// Define MANDEL_MUL_REG_EN when the multiplier has one output register stage (2 cycles per MUL_* state).
module mandel_iter_ctrl #(
  parameter int          ITER_W    = 16,
  parameter logic [31:0] ESCAPE_R2 = 32'h0080_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [31:0]       c_re,
  input  logic [31:0]       c_im,
  input  logic [ITER_W-1:0] max_iter,
  output logic              busy,
  output logic              done,
  output logic              escaped,
  output logic [ITER_W-1:0] iter_count,
  output logic [31:0]       mul_a,
  output logic [31:0]       mul_b,
  input  logic [31:0]       mul_p
);

  typedef enum logic [2:0] {IDLE, MUL_XX, MUL_YY, MUL_XY, UPDATE, DONE} state_t;

  localparam logic signed [32:0] ESC_TH = {ESCAPE_R2[31], ESCAPE_R2};

  state_t            state, state_nx;
  logic [31:0]       x, y, xx, yy, xy, cr, ci;
  logic [31:0]       x_nx, y_nx, opa_nx, opb_nx;
  logic [ITER_W-1:0] max_r, iter_nx, iter_inc;
  logic              esc_nx, accept, is_mul, mul_done;
  logic signed [32:0] mag;

  assign accept   = (state == IDLE) && start && !abort;
  assign is_mul   = (state == MUL_XX) || (state == MUL_YY) || (state == MUL_XY);
  assign iter_inc = iter_count + 1'b1;
  assign mag      = $signed({xx[31], xx}) + $signed({yy[31], yy});
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

`ifdef MANDEL_MUL_REG_EN
  // ph=0: operands issued, ph=1: registered product valid on mul_p
  logic ph;
  assign mul_done = ph;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ph <= 1'b0;
    else     ph <= is_mul && !ph && !abort;
  end
`else
  assign mul_done = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    x_nx     = x;
    y_nx     = y;
    iter_nx  = iter_count;
    esc_nx   = escaped;
    case (state)
      IDLE: if (accept) begin
        x_nx     = '0;
        y_nx     = '0;
        iter_nx  = '0;
        esc_nx   = 1'b0;
        state_nx = (max_iter == '0) ? DONE : MUL_XX;
      end
      MUL_XX: if (mul_done) state_nx = MUL_YY;
      MUL_YY: if (mul_done) state_nx = MUL_XY;
      MUL_XY: if (mul_done) state_nx = UPDATE;
      UPDATE: if (mag > ESC_TH) begin
        esc_nx   = 1'b1;
        state_nx = DONE;
      end else begin
        x_nx     = xx - yy + cr;
        y_nx     = (xy << 1) + ci;
        iter_nx  = iter_inc;
        state_nx = (iter_inc == max_r) ? DONE : MUL_XX;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // abort freezes results and drops back to IDLE from any busy state
    if (abort && state != IDLE) begin
      state_nx = IDLE;
      x_nx     = x;
      y_nx     = y;
      iter_nx  = iter_count;
      esc_nx   = escaped;
    end
    // operands are registered for the state being entered, using post-update z
    opa_nx = '0;
    opb_nx = '0;
    case (state_nx)
      MUL_XX:  begin opa_nx = x_nx; opb_nx = x_nx; end
      MUL_YY:  begin opa_nx = y_nx; opb_nx = y_nx; end
      MUL_XY:  begin opa_nx = x_nx; opb_nx = y_nx; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x          <= '0;
      y          <= '0;
      xx         <= '0;
      yy         <= '0;
      xy         <= '0;
      cr         <= '0;
      ci         <= '0;
      max_r      <= '0;
      iter_count <= '0;
      escaped    <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
    end else begin
      x          <= x_nx;
      y          <= y_nx;
      iter_count <= iter_nx;
      escaped    <= esc_nx;
      mul_a      <= opa_nx;
      mul_b      <= opb_nx;
      if (accept) begin
        cr    <= c_re;
        ci    <= c_im;
        max_r <= max_iter;
      end
      if (is_mul && mul_done && !abort) begin
        case (state)
          MUL_XX:  xx <= mul_p;
          MUL_YY:  yy <= mul_p;
          MUL_XY:  xy <= mul_p;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mandel_iter_ctrl.sv
// Bench for mandel_iter_ctrl: directed scenarios plus random c values against an arithmetic model.
module tb_mandel_iter_ctrl;
  localparam int ITER_W = 16;
`ifdef MANDEL_MUL_REG_EN
  localparam int CPI = 7;
`else
  localparam int CPI = 4;
`endif

  logic              clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [31:0]       c_re = '0, c_im = '0, mul_a, mul_b, mul_p;
  logic [ITER_W-1:0] max_iter = '0, iter_count;
  logic              busy, done, escaped;
  int tests = 0, fails = 0;

  mandel_iter_ctrl #(.ITER_W(ITER_W), .ESCAPE_R2(32'h0080_0000)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .c_re(c_re), .c_im(c_im),
    .max_iter(max_iter), .busy(busy), .done(done), .escaped(escaped),
    .iter_count(iter_count), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p));

  always #5 clk = ~clk;

  function automatic logic [31:0] qmul(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[52:21];
  endfunction

  // Multiplier seen by the DUT
`ifdef MANDEL_MUL_REG_EN
  always_ff @(posedge clk) mul_p <= qmul(mul_a, mul_b);
`else
  assign mul_p = qmul(mul_a, mul_b);
`endif

  // Reference: plain complex-recurrence arithmetic; passes = number of multiply rounds performed
  function automatic void model(input int cr, input int ci, input int mi,
                                output bit esc, output int it, output int passes);
    int x, y, xx, yy, xy;
    longint mag;
    x = 0; y = 0; esc = 0; it = 0; passes = 0;
    while (mi != 0) begin
      passes++;
      xx  = int'(qmul(x, x));
      yy  = int'(qmul(y, y));
      xy  = int'(qmul(x, y));
      mag = longint'(xx) + longint'(yy);
      if (mag > 64'sh80_0000) begin esc = 1; break; end
      x  = xx - yy + cr;
      y  = 2 * xy + ci;
      it++;
      if (it == mi) break;
    end
  endfunction

  task automatic chk(input string tag, input longint got, input longint exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic run(input string tag, input int cr, input int ci, input int mi);
    bit e; int it, ps, lat, n;
    logic ops_zero;
    model(cr, ci, mi, e, it, ps);
    lat = (mi == 0) ? 1 : CPI * ps + 1;
    @(negedge clk);
    start = 1'b1; c_re = cr; c_im = ci; max_iter = mi[ITER_W-1:0];
    @(posedge clk); #1 start = 1'b0;
    n = 0; ops_zero = 1'b1;
    do begin
      @(negedge clk); n++;
      if (mul_a != 0 || mul_b != 0) ops_zero = 1'b0;
    end while (!done && n < 4000);
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_escaped"}, escaped, e);
    chk({tag, "_iter"}, iter_count, it);
    if (mi == 0) chk({tag, "_ops_zero"}, ops_zero, 1);
    @(negedge clk);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_done_after"}, done, 0);
    chk({tag, "_iter_held"}, iter_count, it);
  endtask

  initial begin
    bit e; int it, ps;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_esc", escaped, 0);
    chk("rst_iter", iter_count, 0);
    chk("rst_ops", {mul_a, mul_b}, 0);
    rst = 1'b0;

    run("t1_zero", 0, 0, 16);
    chk("t1_lat_const", CPI * 16 + 1, (CPI == 4) ? 65 : 113);
    run("t2_c2", 32'h0040_0000, 0, 100);
    model(32'h0040_0000, 0, 100, e, it, ps);
    chk("t2_model_iter", it, 2);
    run("t3_cm2", 32'hFFC0_0000, 0, 8);
    run("t4_max0", 32'h0012_3456, 32'h0001_0000, 0);

    // t5: abort at cycle k+10, start re-pulsed mid-run
    @(negedge clk);
    start = 1'b1; c_re = 0; c_im = 0; max_iter = 50;
    @(posedge clk); #1 start = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      start = (n == 5);
      if (done) chk("t5_no_done", done, 0);
    end
    @(negedge clk);
    start = 1'b0;
    chk("t5_busy_pre", busy, 1);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("t5_idle", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_iter_held", iter_count, 9 / CPI);
    chk("t5_esc_held", escaped, 0);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("t5_abort_start_ign", busy, 0);

    // t6: async reset while in the first MUL_XY
    @(negedge clk);
    start = 1'b1; c_re = 32'h0040_0000; c_im = 0; max_iter = 100;
    @(posedge clk); #1 start = 1'b0;
    repeat ((CPI == 4) ? 3 : 5) @(negedge clk);
    chk("t6_busy_pre", busy, 1);
    rst = 1'b1; #1;
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_iter", iter_count, 0);
    chk("t6_ops", {mul_a, mul_b}, 0);
    @(negedge clk); rst = 1'b0;
    run("t6_rerun", 32'h0040_0000, 0, 100);

    for (int i = 0; i < 16; i++) begin
      int cr, ci, mi;
      cr = int'($urandom_range(0, 32'h0080_0000)) - 32'h0040_0000;
      ci = int'($urandom_range(0, 32'h0060_0000)) - 32'h0030_0000;
      mi = int'($urandom_range(1, 30));
      run($sformatf("rnd%0d", i), cr, ci, mi);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
